// File: rtl/noc_to_di_buffer_pkg.sv
// Shared debug-interconnect definitions: flit widths, the header ODD bit and the DI word type.
package noc_to_di_buffer_pkg;

  localparam int NOC_FLIT_WIDTH = 32;
  localparam int DI_FLIT_WIDTH  = 16;
  localparam int HDR_ODD_BIT    = 16;

  typedef struct packed {
    logic [DI_FLIT_WIDTH-1:0] data;
    logic                     valid;
    logic                     last;
  } dii_flit;

endpackage

// File: rtl/noc_to_di_buffer_if.sv
// NoC-side flit input and DI-side word output of the NoC-to-DI splitter.
// Handshake: a transfer happens on a rising clk edge where valid and ready are both high; a source
// must hold its payload stable while valid is high and ready is low.
interface noc_to_di_buffer_if;
  import noc_to_di_buffer_pkg::*;

  logic [NOC_FLIT_WIDTH-1:0] in_flit_data;
  logic                      in_flit_valid;
  logic                      in_flit_last;
  logic                      in_flit_ready;
  dii_flit                   out_flit;
  logic                      out_flit_ready;

  modport slave (
    input  in_flit_data,
    input  in_flit_valid,
    input  in_flit_last,
    output in_flit_ready,
    output out_flit,
    input  out_flit_ready
  );

  modport master (
    output in_flit_data,
    output in_flit_valid,
    output in_flit_last,
    input  in_flit_ready,
    input  out_flit,
    output out_flit_ready
  );

endinterface

// File: rtl/noc_to_di_buffer.sv
// Splits 32-bit NoC packets into 16-bit DI words through a single registered output slot.
// The header gives one word; body flits give LSB then MSB, except an odd final flit (LSB only).
module noc_to_di_buffer
  import noc_to_di_buffer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  noc_to_di_buffer_if.slave   bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    BODY  = 2'd1,
    UPPER = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  dii_flit                  r_out;
  logic [DI_FLIT_WIDTH-1:0] r_msb;
  logic                     r_msb_last;
  logic                     r_odd;

  logic                     w_slot_free;
  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_load;
  logic [DI_FLIT_WIDTH-1:0] w_load_data;
  logic                     w_load_last;
  logic                     w_cap_hdr;
  logic                     w_cap_body;

  // The slot may be refilled in the same cycle its current word is read.
  assign w_slot_free = ~r_out.valid | bus.out_flit_ready;
  assign w_in_ready  = (r_state != UPPER) & w_slot_free & ~rst;
  assign w_accept    = bus.in_flit_valid & w_in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HDR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR: begin
        if (w_accept && !bus.in_flit_last) w_next = BODY;
      end
      BODY: begin
        if (w_accept) w_next = (bus.in_flit_last && r_odd) ? HDR : UPPER;
      end
      UPPER: begin
        if (w_slot_free) w_next = r_msb_last ? HDR : BODY;
      end
      default: w_next = HDR;
    endcase
  end

  always_comb begin
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_last = 1'b0;
    w_cap_hdr   = 1'b0;
    w_cap_body  = 1'b0;
    case (r_state)
      HDR: begin
        w_load      = w_accept;
        w_load_data = bus.in_flit_data[DI_FLIT_WIDTH-1:0];
        w_load_last = bus.in_flit_last;
        w_cap_hdr   = w_accept;
      end
      BODY: begin
        w_load      = w_accept;
        w_load_data = bus.in_flit_data[DI_FLIT_WIDTH-1:0];
        w_load_last = bus.in_flit_last & r_odd;
        w_cap_body  = w_accept;
      end
      UPPER: begin
        w_load      = w_slot_free;
        w_load_data = r_msb;
        w_load_last = r_msb_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out      <= '0;
      r_msb      <= '0;
      r_msb_last <= 1'b0;
      r_odd      <= 1'b0;
    end else begin
      if (w_slot_free) begin
        if (w_load) begin
          r_out.data  <= w_load_data;
          r_out.valid <= 1'b1;
          r_out.last  <= w_load_last;
        end else begin
          r_out.valid <= 1'b0;
          r_out.last  <= 1'b0;
        end
      end
      if (w_cap_hdr) r_odd <= bus.in_flit_data[HDR_ODD_BIT];
      if (w_cap_body) begin
        r_msb      <= bus.in_flit_data[NOC_FLIT_WIDTH-1:DI_FLIT_WIDTH];
        r_msb_last <= bus.in_flit_last;
      end
    end
  end

  assign bus.in_flit_ready = w_in_ready;
  assign bus.out_flit      = r_out;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_noc_to_di_buffer.sv
// Bench for noc_to_di_buffer: directed packets plus random traffic, scored against a packet-level model.
module tb_noc_to_di_buffer;
  import noc_to_di_buffer_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;

  noc_to_di_buffer_if bus ();

  noc_to_di_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];
  int          out_cyc_q[$];
  bit          m_in_pkt = 1'b0;
  bit          m_odd = 1'b0;
  bit          prev_stall = 1'b0;
  dii_flit     prev_out;
  int          stall_count = 0;

  // sink behaviour: 0 always ready, 1 random, 2 scripted then ready
  int          sink_mode = 0;
  bit          sink_script[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: header -> its low half; body -> low then high; final body of an odd packet -> low only.
  task automatic model_accept(input logic [31:0] d, input logic l);
    if (!m_in_pkt) begin
      exp_q.push_back({l, d[15:0]});
      if (!l) begin
        m_in_pkt = 1'b1;
        m_odd    = d[16];
      end
    end else if (!l) begin
      exp_q.push_back({1'b0, d[15:0]});
      exp_q.push_back({1'b0, d[31:16]});
    end else begin
      m_in_pkt = 1'b0;
      if (m_odd) begin
        exp_q.push_back({1'b1, d[15:0]});
      end else begin
        exp_q.push_back({1'b0, d[15:0]});
        exp_q.push_back({1'b1, d[31:16]});
      end
    end
  endtask

  // monitor + model, evaluated mid-cycle for the transfers of the coming edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_in_pkt   = 1'b0;
      m_odd      = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {15'h0, bus.out_flit.valid, bus.out_flit.last, bus.out_flit.data},
              {15'h0, 1'b1, prev_out.last, prev_out.data});
      end
      if (bus.out_flit.valid && bus.out_flit_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h last=%0b expected no word", bus.out_flit.data,
                   bus.out_flit.last);
        end else begin
          check("di_word", {15'h0, bus.out_flit.last, bus.out_flit.data}, {15'h0, exp_q.pop_front()});
          out_cyc_q.push_back(cyc);
        end
      end
      prev_stall = bus.out_flit.valid && !bus.out_flit_ready;
      if (prev_stall) stall_count++;
      prev_out = bus.out_flit;
      if (bus.in_flit_valid && bus.in_flit_ready) model_accept(bus.in_flit_data, bus.in_flit_last);
    end
  end

  // ---------------- sink driver ----------------
  initial begin
    bus.out_flit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (sink_mode)
        1:       bus.out_flit_ready = 1'($urandom_range(0, 1));
        2:       bus.out_flit_ready = (sink_script.size() > 0) ? sink_script.pop_front() : 1'b1;
        default: bus.out_flit_ready = 1'b1;
      endcase
    end
  end

  // ---------------- source driver tasks (all return at posedge+1) ----------------
  task automatic send_flit(input logic [31:0] d, input logic l, output int acc);
    bit ok = 1'b0;
    bus.in_flit_data  = d;
    bus.in_flit_valid = 1'b1;
    bus.in_flit_last  = l;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.in_flit_ready) begin
        ok = 1'b1;
        break;
      end
    end
    acc = cyc;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: flit 0x%0h never accepted", d);
    end
    @(posedge clk);
    #1;
    bus.in_flit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.out_flit.valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int hdr_acc;
    int base;
    int s0;
    int nflits;
    logic [31:0] d;

    bus.in_flit_data  = '0;
    bus.in_flit_valid = 1'b0;
    bus.in_flit_last  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'h0, bus.in_flit_ready}, 32'h0);
    check("rst_valid", {31'h0, bus.out_flit.valid}, 32'h0);
    check("rst_last", {31'h0, bus.out_flit.last}, 32'h0);
    check("rst_data", {16'h0, bus.out_flit.data}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // odd packet, always-ready sink: four words on consecutive cycles after the header
    base = out_cyc_q.size();
    send_flit(32'h0001_0042, 1'b0, hdr_acc);
    send_flit(32'hBBBB_AAAA, 1'b0, acc);
    send_flit(32'h0000_CCCC, 1'b1, acc);
    drain();
    check("odd_pkt_words", out_cyc_q.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < out_cyc_q.size()) check("odd_pkt_timing", out_cyc_q[base+i], hdr_acc + 1 + i);
    end

    // even packet: no input accepted while the MSB is pending
    send_flit(32'h0000_0010, 1'b0, acc);
    send_flit(32'h2222_1111, 1'b1, acc);
    @(negedge clk);
    check("upper_in_ready", {31'h0, bus.in_flit_ready}, 32'h0);
    @(posedge clk);
    #1;
    drain();

    // same packet with the sink stalling twice on the header word
    sink_script = '{1'b1, 1'b0, 1'b0, 1'b1};
    sink_mode   = 2;
    s0          = stall_count;
    base        = out_cyc_q.size();
    send_flit(32'h0000_0010, 1'b0, acc);
    send_flit(32'h2222_1111, 1'b1, acc);
    drain();
    check("stall_cycles", stall_count - s0, 2);
    check("stall_pkt_words", out_cyc_q.size() - base, 3);
    sink_mode = 0;

    // single-flit packet: ODD ignored, valid drops after the read, back in HDR
    send_flit(32'hFFFF_0007, 1'b1, acc);
    @(negedge clk);
    check("single_valid", {15'h0, bus.out_flit.valid, bus.out_flit.last, bus.out_flit.data},
          {15'h0, 1'b1, 1'b1, 16'h0007});
    @(negedge clk);
    check("single_valid_clear", {31'h0, bus.out_flit.valid}, 32'h0);
    check("single_state_hdr", {30'h0, dbg_state}, 32'h0);
    @(posedge clk);
    #1;

    // two packets back-to-back: continuous output stream
    base = out_cyc_q.size();
    send_flit(32'h0000_0100, 1'b0, acc);
    send_flit(32'h1234_5678, 1'b1, acc);
    send_flit(32'h0001_0200, 1'b0, acc);
    send_flit(32'h9ABC_DEF0, 1'b0, acc);
    send_flit(32'h0000_3333, 1'b1, acc);
    drain();
    check("b2b_words", out_cyc_q.size() - base, 7);
    for (int i = 1; i < 7; i++) begin
      if (base + i < out_cyc_q.size()) check("b2b_no_bubble", out_cyc_q[base+i], out_cyc_q[base] + i);
    end

    // reset while the MSB is pending discards the packet
    send_flit(32'h0000_0020, 1'b0, acc);
    send_flit(32'h4444_3333, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'h0, bus.out_flit.valid}, 32'h0);
    check("mid_rst_state", {30'h0, dbg_state}, 32'h0);
    @(posedge clk);
    #1;
    base = out_cyc_q.size();
    send_flit(32'h0000_0055, 1'b1, acc);
    drain();
    check("post_rst_words", out_cyc_q.size() - base, 1);

    // random packets against a random sink
    sink_mode = 1;
    for (int p = 0; p < 40; p++) begin
      nflits = $urandom_range(1, 5);
      for (int f = 0; f < nflits; f++) begin
        d = $urandom;
        send_flit(d, (f == nflits - 1), acc);
        idle($urandom_range(0, 2));
      end
    end
    sink_mode = 0;
    drain();
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_to_di_buffer.md
NOC_TO_DI_BUFFER -- requirements
Module: noc_to_di_buffer

Interface
REQ-001 The block SHALL have no parameters; NOC_FLIT_WIDTH=32 and DI_FLIT_WIDTH=16 SHALL be fixed constants.
REQ-002 The block SHALL have input `clk`, 1 bit: the clock.
REQ-003 The block SHALL have input `rst`, 1 bit: reset, synchronous, active-high; the clock is `clk`.
REQ-004 The block SHALL have input `in_flit_data`, 32 bits: NoC flit payload.
REQ-005 The block SHALL have input `in_flit_valid`, 1 bit: NoC flit valid.
REQ-006 The block SHALL have input `in_flit_last`, 1 bit: last NoC flit of packet.
REQ-007 The block SHALL have output `in_flit_ready`, 1 bit: NoC flit accepted when valid and ready.
REQ-008 The block SHALL have output `out_flit`, of type dii_flit (data 16, valid, last): DI word toward debug interconnect.
REQ-009 The block SHALL have input `out_flit_ready`, 1 bit: DI sink accepts when `out_flit.valid` and `out_flit_ready` are both high.

Function
REQ-010 The block SHALL perform the inverse of DI-to-NoC packing: 32-bit NoC packets SHALL be split into 16-bit DI words, one DI word per cycle maximum.
REQ-011 The first NoC flit of a packet (header) SHALL yield exactly one DI word equal to bits [15:0].
- Header bit [16] = ODD: when set, the final NoC flit carries only a valid LSB half.
- Header bits [31:17] SHALL be ignored.
REQ-012 Each non-final body flit SHALL yield two DI words, LSB half [15:0] first, then MSB half [31:16].
REQ-013 The final body flit SHALL yield LSB then MSB when ODD=0, and LSB only, marked last, when ODD=1.
REQ-014 `out_flit.last` SHALL be 1 only on the final DI word of a packet.
REQ-015 A header arriving with `in_flit_last`=1 SHALL yield one DI word with last=1, regardless of ODD.
REQ-016 The output SHALL be registered: `out_flit` is driven solely from flops, with latency of 1 cycle from accepted NoC flit to its first DI word being valid.
REQ-017 Slot-free is defined as `~out_flit.valid | out_flit_ready`; a new DI word SHALL be loaded only when slot-free is high, and otherwise the output SHALL hold stable.
REQ-018 The state machine SHALL have three states: HDR, BODY and UPPER.
- HDR: `in_flit_ready` = slot-free. On accept, load data[15:0] and capture ODD. Go to BODY if not last, else stay in HDR.
- BODY: `in_flit_ready` = slot-free. On accept, load data[15:0] and store data[31:16] and `in_flit_last`. If last and ODD, output last=1 and go to HDR; otherwise go to UPPER with output last=0.
- UPPER: `in_flit_ready` = 0. When slot-free, load the stored MSB with the stored last flag. Go to HDR if last, else go to BODY.
REQ-019 When slot-free is high and no word is loaded, `out_flit.valid` SHALL clear on the cycle after the read.
REQ-020 Back-to-back packets SHALL incur no idle cycle: the HDR state accepts a new header in the same cycle the previous packet's last word is read.
REQ-021 Sustained throughput SHALL be one DI word per cycle; a body NoC flit is accepted at most every 2nd cycle.
REQ-022 `in_flit_ready` SHALL depend combinationally on `out_flit_ready`; this is intentional, and a FIFO sits on both sides of the block.

Reset
REQ-023 On `rst`, the state SHALL be HDR, `out_flit.valid`=0, `out_flit.last`=0, `out_flit.data`=16'h0, the stored MSB=0, the stored last=0 and ODD=0.
REQ-024 A reset asserted mid-packet SHALL discard the partial packet; the first accepted flit after reset SHALL be treated as a header.
REQ-025 `in_flit_ready` SHALL be 0 while `rst` is high.

Structure
REQ-026 NOC_FLIT_WIDTH, DI_FLIT_WIDTH and the header ODD bit index (16) SHALL live in the shared dii package alongside dii_flit.
REQ-027 The block SHALL be a single module with no sub-modules; the state enum SHALL be local.

Verification
REQ-028 The bench SHALL cover: header 0x0001_0042 (ODD=1), body 0xBBBB_AAAA, last 0x0000_CCCC -> DI words 0x0042, 0xAAAA, 0xBBBB, 0xCCCC(last), in 5 cycles with sink always ready.
REQ-029 The bench SHALL cover: header 0x0000_0010 (ODD=0), last 0x2222_1111 -> DI words 0x0010, 0x1111, 0x2222(last); `in_flit_ready`=0 during the UPPER cycle.
REQ-030 The bench SHALL cover: sink ready toggling 1,0,0,1 during the REQ-029 packet -> the same three words, `out_flit.data` stable while stalled, and no duplicated or lost words.
REQ-031 The bench SHALL cover: a single-flit packet 0xFFFF_0007 with last=1 -> one DI word 0x0007 with last=1, and the state returns to HDR.
REQ-032 The bench SHALL cover: two packets back-to-back with an always-ready sink -> a continuous valid DI stream with no bubble between the last of packet 1 and the header of packet 2.
REQ-033 The bench SHALL cover: `rst` asserted in UPPER -> next cycle `out_flit.valid`=0, and the next flit 0x0000_0055 is emitted as header word 0x0055.
